// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one synchronous RAM port among NUM_REQ requesters
// Optional grant-hold on lock[] when RAM_ARB_LOCK_EN is defined.
module ram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rd_valid,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_q
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, last, rr_win, win;
  logic               we_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [DATA_W-1:0]  rdata_hold;
  int                 cand;

  // Walk from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    rr_win = last;
    cand   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(last) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[IDX_W'(cand)]) rr_win = IDX_W'(cand);
    end
  end

`ifdef RAM_ARB_LOCK_EN
  logic [3:0] lock_cnt;
  logic       lock_hit;

  // lock_cnt counts consecutive grants to a locking requester; at 8 the rotation gets one turn.
  assign lock_hit = req[last] & lock[last] & (lock_cnt < 4'd8);
  assign win      = lock_hit ? last : rr_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= 4'd0;
    end else if (state == IDLE && |req) begin
      if (!lock[win])    lock_cnt <= 4'd0;
      else if (lock_hit) lock_cnt <= lock_cnt + 4'd1;
      else               lock_cnt <= 4'd1;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign win         = rr_win;
`endif

  always_comb begin
    state_next = state;
    gnt        = '0;
    ack        = '0;
    busy       = 1'b0;
    rd_valid   = 1'b0;
    ram_we     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = RESP;
        gnt[idx]   = 1'b1;
        busy       = 1'b1;
        ram_we     = we_r & ~rst;
      end
      RESP: begin
        state_next = IDLE;
        ack[idx]   = 1'b1;
        busy       = 1'b1;
        rd_valid   = ~we_r;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_addr  = addr_r;
  assign ram_wdata = wdata_r;
  assign rdata     = rd_valid ? ram_q : rdata_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IDX_W'(NUM_REQ - 1);
      idx        <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_hold <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |req) begin
        idx     <= win;
        we_r    <= req_we[win];
        addr_r  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        wdata_r <= req_wdata[int'(win)*DATA_W +: DATA_W];
      end
      if (state == RESP) begin
        last <= idx;
        if (!we_r) rdata_hold <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a behavioural 64x8 RAM
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    lock = '0;
  logic [N-1:0]    gnt, ack;
  logic [DW-1:0]   rdata;
  logic            rd_valid, busy;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_we;
  logic [DW-1:0]   ram_q;

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .lock(lock), .gnt(gnt), .ack(ack), .rdata(rdata),
    .rd_valid(rd_valid), .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registered read, output unchanged on a write cycle.
  logic [DW-1:0] mem [64];
  logic          ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < 64; a++) mem[a] <= 8'(a * 3 + 1);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end else begin
      ram_q <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int idx; logic rv; logic [7:0] rd;} exp_t;
  typedef struct {int idx; logic rv; logic [7:0] rd; int cyc;} obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];
  int total = 0;
  int bad = 0;
  int onehot_err = 0;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 3 + 1);
  endfunction

  task automatic start(input int i, input logic w, input int a, input logic [7:0] d);
    req_we[i]            = w;
    req_addr[i*AW +: AW] = AW'(a);
    req_wdata[i*DW +: DW] = d;
    req[i]               = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Appends every ack seen to obs_q until n acks or the cycle budget runs out.
  task automatic collect(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if ($countones(gnt) > 1 || $countones(ack) > 1) onehot_err++;
      if (ack != '0) begin
        obs_t o;
        o.idx = -1;
        for (int k = 0; k < N; k++) if (ack[k]) o.idx = k;
        o.rv  = rd_valid;
        o.rd  = rdata;
        o.cyc = cyc;
        obs_q.push_back(o);
        got++;
      end
    end
  endtask

  task automatic one_access(input int i, input logic w, input int a, input logic [7:0] d,
                            input logic exp_rv, input logic [7:0] exp_rd);
    int got, t0;
    exp_t e;
    obs_t o;
    obs_q.delete();
    exp_q.push_back('{i, exp_rv, exp_rd});
    @(posedge clk); #1;
    start(i, w, a, d);
    t0 = cyc;
    collect(1, 12, got);
    @(posedge clk); #1;
    req[i] = 1'b0;
    total++;
    if (got !== 1) begin
      bad++;
      $display("FAIL access_ack r%0d: got %0d acks want 1", i, got);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if (o.idx !== e.idx) begin bad++; $display("FAIL ack_idx: got %0d want %0d", o.idx, e.idx); end
      if (o.rv !== e.rv) begin bad++; $display("FAIL rd_valid r%0d: got %0b want %0b", i, o.rv, e.rv); end
      if (o.rd !== e.rd) begin bad++; $display("FAIL rdata r%0d: got %h want %h", i, o.rd, e.rd); end
      if (o.cyc - t0 !== 2) begin bad++; $display("FAIL ack_latency: got %0d want 2", o.cyc - t0); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ram_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;
    @(negedge clk);
    total += 6;
    if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    if (ack !== '0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    one_access(0, 1'b1, 5, 8'hAA, 1'b0, 8'h00);
    one_access(0, 1'b0, 5, 8'h00, 1'b1, 8'hAA);
    one_access(0, 1'b1, 6, 8'h11, 1'b0, 8'hAA);
    one_access(0, 1'b0, 6, 8'h00, 1'b1, 8'h11);
  endtask

  task automatic test_round_robin();
    int got;
    exp_t e;
    obs_t o;
    do_reset();
    obs_q.delete();
    onehot_err = 0;
    for (int k = 0; k < 12; k++) exp_q.push_back('{k % N, 1'b1, init_val(10 + k % N)});
    for (int i = 0; i < N; i++) start(i, 1'b0, 10 + i, 8'h00);
    collect(12, 60, got);
    @(posedge clk); #1;
    req = '0;
    total += 2;
    if (got !== 12) begin bad++; $display("FAIL rr_count: got %0d want 12", got); end
    if (onehot_err !== 0) begin bad++; $display("FAIL rr_onehot: got %0d violations want 0", onehot_err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) continue;
      o = obs_q.pop_front();
      total += 2;
      if (o.idx !== e.idx) begin bad++; $display("FAIL rr_order: got %0d want %0d", o.idx, e.idx); end
      if (o.rd !== e.rd) begin bad++; $display("FAIL rr_rdata r%0d: got %h want %h", e.idx, o.rd, e.rd); end
    end
  endtask

  task automatic test_simultaneous();
    int got1, got2;
    exp_t e;
    obs_t o;
    one_access(1, 1'b0, 14, 8'h00, 1'b1, init_val(14));
    obs_q.delete();
    exp_q.push_back('{3, 1'b1, init_val(17)});
    exp_q.push_back('{1, 1'b1, init_val(15)});
    @(posedge clk); #1;
    start(1, 1'b0, 15, 8'h00);
    start(3, 1'b0, 17, 8'h00);
    collect(1, 12, got1);
    @(posedge clk); #1;
    req[3] = 1'b0;
    collect(1, 12, got2);
    @(posedge clk); #1;
    req[1] = 1'b0;
    total++;
    if (got1 + got2 !== 2) begin bad++; $display("FAIL simul_count: got %0d want 2", got1 + got2); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) continue;
      o = obs_q.pop_front();
      total += 2;
      if (o.idx !== e.idx) begin bad++; $display("FAIL simul_order: got %0d want %0d", o.idx, e.idx); end
      if (o.rd !== e.rd) begin bad++; $display("FAIL simul_rdata: got %h want %h", o.rd, e.rd); end
    end
  endtask

  task automatic test_reset_mid_access();
    int seen, acks;
    do_reset();
    seen = 0;
    start(0, 1'b1, 9, 8'h55);
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (gnt[0]) seen = 1;
    end
    total++;
    if (seen !== 1) begin bad++; $display("FAIL mid_gnt: got %0d want 1", seen); end
    rst = 1'b1;
    #1;
    total++;
    if (ram_we !== 1'b0) begin bad++; $display("FAIL mid_ram_we: got %b want 0", ram_we); end
    @(posedge clk); #1;
    rst = 1'b0;
    req[0] = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    total += 2;
    if (acks !== 0) begin bad++; $display("FAIL mid_no_ack: got %0d acks want 0", acks); end
    if (mem[9] !== init_val(9)) begin bad++; $display("FAIL mid_mem9: got %h want %h", mem[9], init_val(9)); end
  endtask

  task automatic test_lock();
    int got;
    exp_t e;
    obs_t o;
    do_reset();
    obs_q.delete();
    for (int k = 0; k < 10; k++) begin
`ifdef RAM_ARB_LOCK_EN
      if (k == 8) exp_q.push_back('{2, 1'b1, init_val(22)});
      else        exp_q.push_back('{0, 1'b1, init_val(20)});
`else
      if (k % 2 == 1) exp_q.push_back('{2, 1'b1, init_val(22)});
      else            exp_q.push_back('{0, 1'b1, init_val(20)});
`endif
    end
    start(0, 1'b0, 20, 8'h00);
    start(2, 1'b0, 22, 8'h00);
    lock[0] = 1'b1;
    collect(10, 50, got);
    @(posedge clk); #1;
    req = '0;
    lock = '0;
    total++;
    if (got !== 10) begin bad++; $display("FAIL lock_count: got %0d want 10", got); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) continue;
      o = obs_q.pop_front();
      total++;
      if (o.idx !== e.idx) begin bad++; $display("FAIL lock_order: got %0d want %0d", o.idx, e.idx); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_simultaneous();
    test_reset_mid_access();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
